// File: rtl/register_bank_if.sv
// Bus bundle for register_bank: write controls, read selects and the datapath-facing outputs.
// The master drives operations and selects; the slave (the bank) drives read data and status.
interface register_bank_if #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = $clog2(NUM_REGS)
);
  logic [WIDTH-1:0]    I;
  logic [NUM_REGS-1:0] RegSel;
  logic [2:0]          FunSel;
  logic [SEL_W-1:0]    OutASel;
  logic [SEL_W-1:0]    OutBSel;
  logic [WIDTH-1:0]    OutA;
  logic [WIDTH-1:0]    OutB;
  logic [NUM_REGS-1:0] Zero;
  logic                WrapEvent;

  modport master (
    output I, RegSel, FunSel, OutASel, OutBSel,
    input  OutA, OutB, Zero, WrapEvent
  );

  modport slave (
    input  I, RegSel, FunSel, OutASel, OutBSel,
    output OutA, OutB, Zero, WrapEvent
  );
endinterface

// File: rtl/register_bank.sv
// Bank of NUM_REGS registers sharing one FunSel operation per edge, with two combinational
// read ports, per-register zero flags and a registered wrap/saturate event pulse.
module register_bank #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = $clog2(NUM_REGS),
  parameter int SATURATE = 0
) (
  input  logic Clock,
  input  logic Reset,
  register_bank_if.slave bus
);

  typedef enum logic [2:0] {
    OP_DEC  = 3'b000,
    OP_INC  = 3'b001,
    OP_LOAD = 3'b010,
    OP_CLR  = 3'b011,
    OP_LDB  = 3'b100,
    OP_LDH  = 3'b101,
    OP_SHB  = 3'b110,
    OP_LDHS = 3'b111
  } fun_sel_e;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0]    regs   [NUM_REGS];
  logic [WIDTH-1:0]    next_q [NUM_REGS];
  logic [NUM_REGS-1:0] hit;
  logic                wrap_q;
  fun_sel_e            op;

  assign op = fun_sel_e'(bus.FunSel);

  // Candidate next value for every register; RegSel only gates the commit.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    hit = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      next_q[k] = regs[k];
      case (op)
        OP_DEC: begin
          if (regs[k] == '0) begin
            hit[k]    = 1'b1;
            next_q[k] = (SATURATE != 0) ? '0 : ALL_ONES;
          end else begin
            next_q[k] = regs[k] - ONE;
          end
        end
        OP_INC: begin
          if (regs[k] == ALL_ONES) begin
            hit[k]    = 1'b1;
            next_q[k] = (SATURATE != 0) ? ALL_ONES : '0;
          end else begin
            next_q[k] = regs[k] + ONE;
          end
        end
        OP_LOAD: next_q[k] = bus.I;
        OP_CLR:  next_q[k] = '0;
        OP_LDB:  next_q[k] = WIDTH'(bus.I[7:0]);
        OP_LDH:  next_q[k] = WIDTH'(bus.I[15:0]);
        OP_SHB:  next_q[k] = {regs[k][WIDTH-9:0], bus.I[7:0]};
        OP_LDHS: next_q[k] = WIDTH'($signed(bus.I[15:0]));
      endcase
    end
  end

  // NOTE: the register array is cleared by reset on purpose; Zero and the read ports
  // must show a defined all-zero bank the instant Reset falls.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      wrap_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge state.
      for (int k = 0; k < NUM_REGS; k++) begin
        if (bus.RegSel[k]) regs[k] <= next_q[k];
      end
      wrap_q <= |(hit & bus.RegSel);
    end
  end

  assign bus.WrapEvent = wrap_q;

  // Indices past the last register read as zero when NUM_REGS is not a power of two.
  always_comb begin
    bus.OutA = '0;
    bus.OutB = '0;
    if ({1'b0, bus.OutASel} < (SEL_W + 1)'(NUM_REGS)) bus.OutA = regs[bus.OutASel];
    if ({1'b0, bus.OutBSel} < (SEL_W + 1)'(NUM_REGS)) bus.OutB = regs[bus.OutBSel];
  end

  always_comb begin
    bus.Zero = '0;
    for (int k = 0; k < NUM_REGS; k++) bus.Zero[k] = (regs[k] == '0);
  end

endmodule

// File: tb/tb_register_bank.sv
// Drives a wrapping and a saturating register_bank with the same stimulus and compares both
// against an arithmetic reference model of the bank.
module tb_register_bank;

  localparam int W = 32;
  localparam int N = 4;
  localparam logic [31:0] MAX = 32'hFFFF_FFFF;

  localparam logic [2:0] F_DEC  = 3'b000;
  localparam logic [2:0] F_INC  = 3'b001;
  localparam logic [2:0] F_LOAD = 3'b010;
  localparam logic [2:0] F_CLR  = 3'b011;
  localparam logic [2:0] F_SHB  = 3'b110;
  localparam logic [2:0] F_LDHS = 3'b111;

  logic clk;
  logic rst_n;

  register_bank_if #(.WIDTH(W), .NUM_REGS(N)) bus0 ();
  register_bank_if #(.WIDTH(W), .NUM_REGS(N)) bus1 ();

  register_bank #(.WIDTH(W), .NUM_REGS(N), .SATURATE(0)) dut_wrap (
    .Clock(clk), .Reset(rst_n), .bus(bus0)
  );
  register_bank #(.WIDTH(W), .NUM_REGS(N), .SATURATE(1)) dut_sat (
    .Clock(clk), .Reset(rst_n), .bus(bus1)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: index 0 wraps, index 1 saturates.
  logic [31:0] m_reg  [2][N];
  bit          m_wrap [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < N; k++) m_reg[s][k] = '0;
      m_wrap[s] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [3:0] rs, input logic [2:0] fs, input logic [31:0] d);
    longint unsigned v;
    for (int s = 0; s < 2; s++) begin
      m_wrap[s] = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (rs[k]) begin
          v = longint'(m_reg[s][k]);
          case (fs)
            3'd0: if (v == 0) begin m_wrap[s] = 1'b1; v = (s == 1) ? 0 : 64'hFFFF_FFFF; end
                  else v = v - 1;
            3'd1: if (v + 1 > 64'hFFFF_FFFF) begin m_wrap[s] = 1'b1; v = (s == 1) ? v : 0; end
                  else v = v + 1;
            3'd2: v = longint'(d);
            3'd3: v = 0;
            3'd4: v = longint'(d) % 256;
            3'd5: v = longint'(d) % 65536;
            3'd6: v = (v * 256 + longint'(d) % 256) % 64'h1_0000_0000;
            default: v = (longint'(d) % 65536 >= 32768) ? longint'(d) % 65536 + 64'hFFFF_0000
                                                       : longint'(d) % 65536;
          endcase
          m_reg[s][k] = v[31:0];
        end
      end
    end
  endtask

  task automatic set_in(input logic [3:0] rs, input logic [2:0] fs, input logic [31:0] d);
    bus0.RegSel = rs; bus0.FunSel = fs; bus0.I = d;
    bus1.RegSel = rs; bus1.FunSel = fs; bus1.I = d;
  endtask

  // Walks both read ports over every register, then checks Zero and WrapEvent.
  task automatic check_all();
    logic [3:0] z0, z1;
    for (int k = 0; k < N; k++) begin
      bus0.OutASel = 2'(k); bus0.OutBSel = 2'(N - 1 - k);
      bus1.OutASel = 2'(k); bus1.OutBSel = 2'(N - 1 - k);
      #1;
      check($sformatf("wrap_outa_r%0d", k), bus0.OutA, m_reg[0][k]);
      check($sformatf("wrap_outb_r%0d", N - 1 - k), bus0.OutB, m_reg[0][N - 1 - k]);
      check($sformatf("sat_outa_r%0d", k), bus1.OutA, m_reg[1][k]);
      check($sformatf("sat_outb_r%0d", N - 1 - k), bus1.OutB, m_reg[1][N - 1 - k]);
    end
    for (int k = 0; k < N; k++) begin
      z0[k] = (m_reg[0][k] == 0);
      z1[k] = (m_reg[1][k] == 0);
    end
    check("wrap_zero", bus0.Zero, z0);
    check("sat_zero", bus1.Zero, z1);
    check("wrap_event", bus0.WrapEvent, m_wrap[0]);
    check("sat_event", bus1.WrapEvent, m_wrap[1]);
  endtask

  task automatic step(input logic [3:0] rs, input logic [2:0] fs, input logic [31:0] d);
    @(negedge clk);
    set_in(rs, fs, d);
    @(posedge clk);
    model_edge(rs, fs, d);
    #1;
    check_all();
  endtask

  task automatic read_wrap(input string tag, input int k, input logic [31:0] exp);
    bus0.OutASel = 2'(k);
    #1;
    check(tag, bus0.OutA, exp);
  endtask

  task automatic read_sat(input string tag, input int k, input logic [31:0] exp);
    bus1.OutASel = 2'(k);
    #1;
    check(tag, bus1.OutA, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    rst_n = 1'b0;
    set_in('0, '0, '0);
    bus0.OutASel = '0; bus0.OutBSel = '0;
    bus1.OutASel = '0; bus1.OutBSel = '0;
    model_reset();
    #3;
    check_all();
    check("reset_zero_mask", bus0.Zero, 4'b1111);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset between edges, then an edge held under reset is discarded.
    step(4'b1111, F_LOAD, 32'hDEAD_BEEF);
    read_wrap("deadbeef_r3", 3, 32'hDEAD_BEEF);
    @(negedge clk);
    set_in(4'b1111, F_INC, 32'h0);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check("async_reset_zero", bus0.Zero, 4'b1111);
    @(posedge clk);
    #1;
    check("reset_held_edge", bus0.Zero, 4'b1111);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(4'b0000, F_CLR, 32'h0);
    @(posedge clk);
    model_edge(4'b0000, F_CLR, 32'h0);
    #1;
    check_all();

    // Load and sign-extended half load.
    step(4'b0001, F_LOAD, 32'h1234_5678);
    step(4'b0010, F_LDHS, 32'h0000_8001);
    read_wrap("load_r0", 0, 32'h1234_5678);
    bus0.OutBSel = 2'd1;
    #1;
    check("ldhs_r1", bus0.OutB, 32'hFFFF_8001);

    // Byte shift chain.
    step(4'b0100, F_CLR, 32'h0);
    step(4'b0100, F_SHB, 32'hAB11);
    step(4'b0100, F_SHB, 32'hCD22);
    step(4'b0100, F_SHB, 32'hEF33);
    step(4'b0100, F_SHB, 32'h0144);
    read_wrap("shift4_r2", 2, 32'h1122_3344);
    step(4'b0100, F_SHB, 32'h0055);
    read_wrap("shift5_r2", 2, 32'h2233_4455);

    // Wrap around the top and bottom.
    step(4'b1000, F_LOAD, MAX);
    step(4'b1000, F_INC, 32'h0);
    read_wrap("wrap_inc_r3", 3, 32'h0);
    check("wrap_inc_event", bus0.WrapEvent, 1'b1);
    step(4'b0000, F_INC, 32'h0);
    check("wrap_event_one_cycle", bus0.WrapEvent, 1'b0);
    step(4'b1000, F_DEC, 32'h0);
    read_wrap("wrap_dec_r3", 3, MAX);
    check("wrap_dec_event", bus0.WrapEvent, 1'b1);

    // Saturation at both ends.
    step(4'b0001, F_CLR, 32'h0);
    step(4'b0001, F_DEC, 32'h0);
    read_sat("sat_dec_r0", 0, 32'h0);
    check("sat_dec_event", bus1.WrapEvent, 1'b1);
    step(4'b0001, F_LOAD, 32'hFFFF_FFFE);
    step(4'b0001, F_INC, 32'h0);
    check("sat_inc1_event", bus1.WrapEvent, 1'b0);
    step(4'b0001, F_INC, 32'h0);
    read_sat("sat_inc2_r0", 0, MAX);
    check("sat_inc2_event", bus1.WrapEvent, 1'b1);

    // Multi-select increment and an all-deselected clear.
    step(4'b0001, F_LOAD, 32'd5);
    step(4'b0010, F_LOAD, 32'd9);
    step(4'b0011, F_INC, 32'h0);
    read_wrap("multi_r0", 0, 32'd6);
    read_wrap("multi_r1", 1, 32'd10);
    check("multi_event", bus0.WrapEvent, 1'b0);
    step(4'b0000, F_CLR, 32'h0);
    read_wrap("hold_r1", 1, 32'd10);

    // Randomized operations biased toward counter boundaries.
    repeat (300) begin
      case ($urandom_range(0, 4))
        0:       d = MAX;
        1:       d = 32'h0;
        2:       d = 32'hFFFF_FFFE;
        3:       d = 32'h1;
        default: d = $urandom;
      endcase
      step(4'($urandom), 3'($urandom), d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Parametrised bank of NUM_REGS general-purpose registers, each WIDTH bits wide, extending the 32-bit single register to multi-register operation.
- All registers selected in a one-hot/multi-hot mask execute the same FunSel operation on the same edge.
- Two independent combinational read ports feed the ALU/address datapath.
- Adds asynchronous reset, selectable wrap/saturate counting and a registered overflow event output.

Parameters:
- WIDTH, 32, register width in bits. Must be a multiple of 8 and >= 16.
- NUM_REGS, 4, number of registers. Must be >= 2.
- SEL_W, $clog2(NUM_REGS), width of the read-port selects.
- SATURATE, 0. 0 = increment/decrement wrap modulo 2^WIDTH; 1 = clamp at all-ones on increment and at zero on decrement.

Ports:
- Clock  input  1  rising-edge clock for all state.
- Reset  input  1  asynchronous, active-low reset.
- I  input  WIDTH  load data, shared by all registers.
- RegSel  input  NUM_REGS  per-register enable mask. Bit k high means register k executes FunSel this edge.
- FunSel  input  3  operation code, encodings listed under Behaviour.
- OutASel  input  SEL_W  read port A register index.
- OutBSel  input  SEL_W  read port B register index.
- OutA  output  WIDTH  contents of register OutASel (combinational).
- OutB  output  WIDTH  contents of register OutBSel (combinational).
- Zero  output  NUM_REGS  bit k high when register k == 0 (combinational).
- WrapEvent  output  1  registered pulse: an increment/decrement overflowed or was clamped on the previous edge.

Behaviour:
- Reset (Reset == 0, asynchronous, any time): all registers clear to 0 immediately; WrapEvent = 0.
- Outputs under reset: OutA = OutB = 0, Zero = all ones.
- Reset mid-operation: the in-flight edge's update is discarded.
- Release of reset takes effect at the next rising Clock edge.
- Update rule: on each rising Clock edge, register k updates only if RegSel[k] == 1; unselected registers hold.
- RegSel == 0: no register changes and WrapEvent goes 0.
- Operation encodings (Q is the register, applied independently to each selected register):
  - 000 decrement: Q-1.
  - 001 increment: Q+1.
  - 010 load: Q = I.
  - 011 clear: Q = 0.
  - 100 load byte: Q = {zeros, I[7:0]}.
  - 101 load half: Q = {zeros, I[15:0]}.
  - 110 byte shift-in: Q = {Q[WIDTH-9:0], I[7:0]}; the top byte is lost.
  - 111 load half sign-extended: Q = {replicate I[15], I[15:0]}.
- When WIDTH == 16, opcodes 101 and 111 both reduce to Q = I[15:0].
- Wrap/saturate:
  - SATURATE = 0: all-ones+1 gives 0; 0-1 gives all-ones.
  - SATURATE = 1: all-ones+1 stays all-ones; 0-1 stays 0.
  - In both modes the boundary condition counts as an event.
- WrapEvent: registered, high for exactly the one cycle after an edge where at least one selected register hit a boundary under opcode 000/001. Otherwise low. Not sticky.
- Read ports:
  - Purely combinational from the register array, so a written value appears on OutA/OutB right after the writing edge.
  - No write-to-read bypass within the same cycle.
  - OutASel and OutBSel may be equal, in which case both ports show the same value.
- Out-of-range select (NUM_REGS not a power of 2, index >= NUM_REGS): the port reads 0.
- Multi-select: several registers with different contents may be incremented in the same edge, each independently. WrapEvent is the OR over them.
- Latency: 1 cycle for write to read-visible; 1 cycle from boundary edge to WrapEvent.

Test Plan:
- Reset: load 0xDEADBEEF into all registers, pulse Reset low between edges -> all OutA/OutB read 0 immediately without a clock edge; Zero = 4'b1111; WrapEvent = 0.
- Load and read: RegSel = 0001, FunSel = 010, I = 0x12345678, then RegSel = 0010, FunSel = 111, I = 0x0000_8001 -> R0 = 0x12345678, R1 = 0xFFFF8001; OutASel = 0, OutBSel = 1 show both; R2 and R3 unchanged at 0.
- Byte shift chain: clear R2, then four edges of FunSel = 110 with I[7:0] = 0x11, 0x22, 0x33, 0x44 -> R2 = 0x11223344. A fifth edge with 0x55 -> R2 = 0x22334455.
- Wrap (SATURATE = 0): R3 = 0xFFFFFFFF, FunSel = 001 -> R3 = 0, Zero[3] = 1, WrapEvent high for exactly one cycle. Then FunSel = 000 -> R3 = 0xFFFFFFFF and WrapEvent pulses again.
- Saturate (SATURATE = 1 instance): R0 = 0, decrement -> R0 stays 0 with WrapEvent pulse. R0 = 0xFFFFFFFE, increment twice -> 0xFFFFFFFF then 0xFFFFFFFF, with WrapEvent only after the second increment.
- Multi-select and hold: R0 = 5, R1 = 9, RegSel = 0011, FunSel = 001 -> R0 = 6, R1 = 10, WrapEvent = 0. Then RegSel = 0000 with FunSel = 011 -> no change.
